// File: rtl/ps2_pkg.sv
// Types and helpers for the PS/2 host transmitter and the keyboard receiver.
package ps2_pkg;

    localparam int unsigned GLITCH_LEN = 8;

    typedef enum logic [3:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StParity,
        StStop,
        StAckWait,
        StDone,
        StError
    } ps2_tx_state_e;

    // 64-bit product: long timeouts at MHz clocks overflow 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq);
        logic [63:0] prod;
        prod = 64'(us) * 64'(freq);
        return 32'(prod / 64'd1_000_000);
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser, glitch filter and falling-edge pulse for one PS/2 line.
// Also used by the keyboard receiver.
module ps2_sync_edge #(
    parameter int unsigned GlitchLen = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(GlitchLen + 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level flips on the GlitchLen-th consecutive sample that disagrees with it.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(GlitchLen - 1)) begin
                level_d = sync_q[1];
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts a byte out
// on device-generated clock falls and checks the device acknowledge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 14000000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned BIT_TIMEOUT_US   = 2000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DAT_IN,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned InhCycles   = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
    localparam int unsigned StartCycles = us_to_cycles(START_TIMEOUT_US, CLK_FREQ_HZ);
    localparam int unsigned BitCycles   = us_to_cycles(BIT_TIMEOUT_US, CLK_FREQ_HZ);
    localparam int unsigned MaxAB       = (StartCycles > BitCycles) ? StartCycles : BitCycles;
    localparam int unsigned MaxCycles   = (MaxAB > InhCycles) ? MaxAB : InhCycles;
    localparam int unsigned TimerW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    logic       clk_filt, clk_fall, dat_s;
    logic [1:0] dat_sync_q;

    ps2_sync_edge #(
        .GlitchLen(GLITCH_LEN)
    ) u_clk_edge (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .line_i (PS2_CLK_IN),
        .level_o(clk_filt),
        .fall_o (clk_fall)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) dat_sync_q <= 2'b11;
        else       dat_sync_q <= {dat_sync_q[0], PS2_DAT_IN};
    end
    assign dat_s = dat_sync_q[1];

    ps2_tx_state_e     state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              par_q, par_d;
    logic [3:0]        idx_q, idx_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic              ready_q, ready_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;
    logic              watched, wd_expired;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        watched = (state_q == StReq) || (state_q == StData) || (state_q == StParity) ||
                  (state_q == StStop) || (state_q == StAckWait);
        wd_expired = (timer_q == '0);

        // Every device clock fall restarts the inter-bit watchdog.
        if (watched) begin
            if (clk_fall)         timer_d = TimerW'(BitCycles - 1);
            else if (!wd_expired) timer_d = timer_q - TimerW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (tx_valid && ready_q) begin
                    data_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    timer_d  = TimerW'(InhCycles - 1);
                    clk_oe_d = 1'b1;
                    dat_oe_d = (InhCycles == 1);
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (timer_q == '0) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    timer_d  = TimerW'(StartCycles - 1);
                    state_d  = StReq;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                    if (timer_q == TimerW'(1)) dat_oe_d = 1'b1;
                end
            end
            StReq: begin
                if (clk_fall) begin
                    dat_oe_d = ~data_q[0];
                    idx_d    = 4'd1;
                    state_d  = StData;
                end
            end
            StData: begin
                if (clk_fall) begin
                    if (idx_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                        state_d  = StParity;
                    end else begin
                        dat_oe_d = ~data_q[idx_q[2:0]];
                        idx_d    = idx_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (clk_fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (clk_fall) begin
                    if (!dat_s) begin
                        state_d = StAckWait;
                    end else begin
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = StError;
                    end
                end
            end
            StAckWait: begin
                if (clk_filt && dat_s) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A fall in the same cycle as expiry keeps the frame alive.
        if (watched && !clk_fall && wd_expired && state_d == state_q) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err_d    = 1'b1;
            state_d  = StError;
        end

        ready_d = (state_d == StIdle);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            data_q   <= '0;
            par_q    <= 1'b0;
            idx_q    <= '0;
            timer_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_done    = done_q;
    assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: open-drain line model plus a PS/2 device model.
// Timeouts are scaled down (1000 us start, 200 us bit) to keep run time short.
module tb_ps2_host_tx;

    localparam int unsigned InhCyc   = 1400;
    localparam int unsigned StartCyc = 14000;
    localparam int unsigned BitCyc   = 2800;
    // Raw fall to registered watchdog reload: 2 sync + 8 filter + fall flop + FSM.
    localparam int unsigned FallLat  = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, clk_oe, dat_oe, busy, tx_done, tx_error;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line, dat_line;

    assign clk_line = ~clk_oe & dev_clk;
    assign dat_line = ~dat_oe & dev_dat;

    ps2_host_tx #(
        .CLK_FREQ_HZ     (14000000),
        .INHIBIT_US      (100),
        .START_TIMEOUT_US(1000),
        .BIT_TIMEOUT_US  (200)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .PS2_CLK_IN(clk_line),
        .PS2_DAT_IN(dat_line),
        .ps2_clk_oe(clk_oe),
        .ps2_dat_oe(dat_oe),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        bit         err;
        bit         chk;
        logic [7:0] b;
        logic       p;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] dev_byte;
    logic       dev_par, dev_stop;
    int         fall_cyc;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && (tx_done || tx_error)) begin
            check("done_err_exclusive", 32'(tx_done & tx_error), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("result_is_error", 32'(tx_error), 32'(e.err));
                if (e.chk) begin
                    check("dev_byte", 32'(dev_byte), 32'(e.b));
                    check("dev_parity", 32'(dev_par), 32'(e.p));
                    check("dev_stop", 32'(dev_stop), 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit push, input bit err, input bit chk,
                        input logic p);
        exp_t e;
        @(posedge clk);
        #1;
        tx_data  = b;
        tx_valid = 1'b1;
        if (push) begin
            e = '{err, chk, b, p};
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Device: waits for request-to-send, clocks nfalls bits, samples data on rises.
    task automatic dev_frame(input int half, input int nfalls, input bit ack, input int glitch_at);
        int n;
        n        = 0;
        dev_byte = 8'h00;
        dev_par  = 1'b0;
        dev_stop = 1'b0;
        while (!(!clk_oe && dat_oe) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20000) begin
            check("dev_req_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < nfalls; i++) begin
            if (i == 10 && ack) dev_dat = 1'b0;
            if (i == glitch_at) begin
                repeat (half / 2) @(posedge clk);
                #1 dev_clk = 1'b0;
                repeat (3) @(posedge clk);
                #1 dev_clk = 1'b1;
                repeat (half - half / 2 - 3) @(posedge clk);
            end else begin
                repeat (half) @(posedge clk);
            end
            #1 dev_clk = 1'b0;
            fall_cyc = cyc;
            repeat (half) @(posedge clk);
            #1 dev_clk = 1'b1;
            if (i < 8)       dev_byte[i] = dat_line;
            else if (i == 8) dev_par = dat_line;
            else if (i == 9) dev_stop = dat_line;
        end
        if (ack) begin
            repeat (20) @(posedge clk);
            #1 dev_dat = 1'b1;
        end
    endtask

    task automatic wait_result(input int budget);
        int n;
        n = 0;
        while (!(tx_done || tx_error) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(tx_done || tx_error)) check("result_timeout", 0, 1);
    endtask

    task automatic measure_inhibit(output int n_clk, output int first_dat);
        n_clk     = 0;
        first_dat = 0;
        while (clk_oe && n_clk < 5000) begin
            n_clk++;
            if (dat_oe && first_dat == 0) first_dat = n_clk;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post_idle();
        @(posedge clk);
        #1;
        check("idle_ready", 32'(tx_ready), 1);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int n_clk, fd, m;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_clk_oe", 32'(clk_oe), 0);
        check("rst_dat_oe", 32'(dat_oe), 0);
        check("rst_done_err", 32'({tx_done, tx_error}), 0);
        rst = 1'b0;

        // 0xED at 12.5 kHz device clock
        send(8'hED, 1, 0, 1, 1'b1);
        check("accept_latency_clk_oe", 32'(clk_oe), 1);
        check("accept_ready_low", 32'(tx_ready), 0);
        fork
            dev_frame(560, 11, 1, -1);
            wait_result(30000);
        join
        post_idle();

        // 0x02 with a stray request while busy
        send(8'h02, 1, 0, 1, 1'b0);
        fork
            dev_frame(100, 11, 1, -1);
            wait_result(30000);
            begin
                repeat (50) @(posedge clk);
                #1;
                check("busy_during_frame", 32'(busy), 1);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                repeat (5) @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        join
        post_idle();

        // 0xFF with inhibit timing
        send(8'hFF, 1, 0, 1, 1'b1);
        fork
            measure_inhibit(n_clk, fd);
            dev_frame(100, 11, 1, -1);
            wait_result(30000);
        join
        check("inhibit_len", 32'(n_clk), InhCyc);
        check("inhibit_dat_cycle", 32'(fd), InhCyc);
        post_idle();

        // Device never clocks: start timeout counted from clock release
        send(8'h3C, 1, 1, 0, 1'b0);
        measure_inhibit(n_clk, fd);
        check("req_start_bit", 32'(dat_oe), 1);
        m = 0;
        while (!tx_error && m < int'(StartCyc) + 100) begin
            @(posedge clk);
            #1;
            m++;
        end
        check("start_timeout_cycles", 32'(m), StartCyc);
        check("start_timeout_oe", 32'({clk_oe, dat_oe}), 0);
        post_idle();

        // Device stops after 4 bits
        send(8'h96, 1, 1, 0, 1'b0);
        dev_frame(100, 4, 0, -1);
        m = 0;
        while (!tx_error && m < int'(BitCyc) + 200) begin
            @(posedge clk);
            #1;
            m++;
        end
        check("bit_timeout_cycles", 32'(cyc - fall_cyc), FallLat + BitCyc);
        check("bit_timeout_oe", 32'({clk_oe, dat_oe}), 0);
        post_idle();

        // Missing acknowledge
        send(8'h5A, 1, 1, 0, 1'b0);
        fork
            dev_frame(100, 11, 0, -1);
            wait_result(30000);
        join
        post_idle();

        // Reset while bit 3 of 0xA5 (a 0) is on the line
        send(8'hA5, 0, 0, 0, 1'b0);
        dev_frame(100, 4, 0, -1);
        check("bit3_driven_low", 32'(dat_oe), 1);
        rst = 1'b1;
        #1;
        check("reset_oe_release", 32'({clk_oe, dat_oe}), 0);
        check("reset_ready", 32'(tx_ready), 1);
        check("reset_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 0xF4 after reset, with a 3-cycle clock glitch mid-byte
        send(8'hF4, 1, 0, 1, 1'b0);
        fork
            dev_frame(100, 11, 1, 5);
            wait_result(30000);
        join
        post_idle();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the sending end of the keyboard PS/2 link, complementing the existing keyboard receiver.
- Sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the standard inhibit / request-to-send / device-clocked frame.
- Sits beside the keyboard receiver in the ULA clock domain (clk_ula, 14 MHz) and drives open-drain enables for PS2_CLK and PS2_DAT.
- Asserts busy so the receiver ignores line activity while a frame is being transmitted.

Parameters:
- CLK_FREQ_HZ, 14000000, frequency of CLK; used to derive the cycle-count constants.
- INHIBIT_US, 100, time PS2_CLK is held low before the request-to-send.
- START_TIMEOUT_US, 15000, maximum wait from clock release to the first device falling edge.
- BIT_TIMEOUT_US, 2000, maximum gap between consecutive device falling edges.

Ports:
- CLK  in  1  system clock (clk_ula).
- RESET  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send; captured on accept.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE; accept happens when tx_valid && tx_ready.
- PS2_CLK_IN  in  1  raw PS/2 clock line (asynchronous).
- PS2_DAT_IN  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and device acknowledged.
- tx_error  out  1  one-cycle pulse: timeout, or ack missing.

Behaviour:
- Reset values (asynchronous): state = IDLE; tx_ready = 1; busy = 0; ps2_clk_oe = 0; ps2_dat_oe = 0; tx_done = 0; tx_error = 0; counters = 0.
- Input conditioning:
  - PS2_CLK_IN and PS2_DAT_IN each pass through a 2-flop synchroniser.
  - The clock line also passes an 8-cycle glitch filter (level changes only after 8 consecutive equal samples).
  - fall = one-cycle pulse on a filtered 1->0 transition.
- Accept: tx_valid && tx_ready captures tx_data and computes odd parity (parity = ~^tx_data). Next cycle: state = INHIBIT, tx_ready = 0.
- INHIBIT:
  - ps2_clk_oe = 1 for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles (1400 at default).
  - ps2_dat_oe = 1 is asserted in the final cycle.
  - Then -> REQ.
- REQ:
  - ps2_clk_oe = 0, ps2_dat_oe = 1 (start bit = 0).
  - Watchdog loads the START_TIMEOUT cycle count.
  - On fall: drive data bit 0, bit index = 1, watchdog loads the BIT_TIMEOUT count, -> DATA.
- DATA:
  - Each fall drives the next bit, LSB first (ps2_dat_oe = ~bit).
  - The fall after bit 7 drives parity -> PARITY.
- PARITY: on fall, ps2_dat_oe = 0 (stop bit = 1) -> STOP.
- STOP: on fall, sample synced data: 0 -> ACK_WAIT; 1 -> ERROR.
- ACK_WAIT: when filtered clock = 1 and synced data = 1 -> DONE.
- DONE: tx_done = 1 for one cycle -> IDLE.
- ERROR:
  - Both oe = 0; tx_error = 1 for one cycle -> IDLE.
  - The captured byte is discarded (no retry in hardware).
- Watchdog:
  - Reloads on every fall.
  - Expiry in REQ, DATA, PARITY, STOP or ACK_WAIT -> ERROR.
  - Width is ceil(log2(START_TIMEOUT cycles)); 18 bits at default.
- Simultaneous events: a fall and watchdog expiry in the same cycle -> the fall wins.
- tx_valid while busy: ignored; the captured byte is unaffected by tx_data changes after accept.
- Reset mid-frame: both oe release immediately (asynchronous). The device times out on its own side; no recovery frame is sent.
- tx_done and tx_error are never high in the same cycle.
- Outputs are registered; latency from accept to ps2_clk_oe = 1 is one cycle.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK_WAIT, DONE, ERROR);
  - function us_to_cycles(us, freq);
  - odd-parity function;
  - GLITCH_LEN = 8.
- Sub-module ps2_sync_edge: synchroniser + glitch filter + falling-edge pulse. Reused by the keyboard receiver.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz -> data on successive falls 1,0,1,1,0,1,1,1, parity 1, stop released; model acks -> tx_done pulse, busy drops, tx_ready = 1.
- Send 0x02 -> parity bit 0. Send 0xFF -> parity 1. Check ps2_clk_oe is held exactly 1400 cycles and ps2_dat_oe asserts in cycle 1400.
- Device never clocks after request -> tx_error exactly 210000 cycles after clock release; both oe = 0.
- Device stops after 4 bits -> tx_error 28000 cycles after the last fall.
- Model does not pull data low at the ack fall -> tx_error, no tx_done.
- Assert RESET during the DATA state (bit 3) -> both oe = 0 in the same cycle, tx_ready = 1. A new 0xF4 request then completes normally. A 3-cycle clock glitch during DATA produces no bit advance.
